// File: rtl/sequential_pulse_monitor_pkg.sv
// rtl/sequential_pulse_monitor_pkg.sv - shared types, widths and one-hot decode helper for the pulse monitor
package seq_pulse_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } mon_state_e;

   localparam int DEF_NUM_PHASES = 6;
   localparam int IDX_W          = $clog2(DEF_NUM_PHASES);
   localparam int MAX_PHASES     = 32;

   // Phase 0 sits on the MSB, so the index counts down from the top bit.
   function automatic int onehot_to_idx(input logic [MAX_PHASES-1:0] vec, input int num_phases);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_PHASES; i++) begin
         if (i < num_phases && vec[i]) idx = num_phases - 1 - i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/sequential_pulse_monitor_if.sv
// rtl/sequential_pulse_monitor_if.sv - pulse bus and monitor status bundle; SEQ_MON_ERR_CLR_EN adds err_clr
interface sequential_pulse_monitor_if
   import seq_pulse_pkg::*;
#(
   parameter int NUM_PHASES = DEF_NUM_PHASES,
   parameter int ERR_CNT_W  = 8
);

   logic [NUM_PHASES-1:0]         pulse_in;
   logic [$clog2(NUM_PHASES)-1:0] phase_idx;
   logic                          phase_vld;
   logic                          locked;
   logic                          seq_done;
   logic                          seq_err;
   logic [ERR_CNT_W-1:0]          err_cnt;

`ifdef SEQ_MON_ERR_CLR_EN
   logic                          err_clr;

   modport master (
      output pulse_in, err_clr,
      input  phase_idx, phase_vld, locked, seq_done, seq_err, err_cnt
   );

   modport slave (
      input  pulse_in, err_clr,
      output phase_idx, phase_vld, locked, seq_done, seq_err, err_cnt
   );
`else
   modport master (
      output pulse_in,
      input  phase_idx, phase_vld, locked, seq_done, seq_err, err_cnt
   );

   modport slave (
      input  pulse_in,
      output phase_idx, phase_vld, locked, seq_done, seq_err, err_cnt
   );
`endif

endinterface

// File: rtl/sequential_pulse_monitor_decode.sv
// rtl/sequential_pulse_monitor_decode.sv - combinational one-hot validity check and phase index decode
module pulse_onehot_decode
   import seq_pulse_pkg::*;
#(
   parameter  int NUM_PHASES = DEF_NUM_PHASES,
   localparam int PH_W       = $clog2(NUM_PHASES)
) (
   input  logic [NUM_PHASES-1:0] in_q,
   output logic                  vld,
   output logic [PH_W-1:0]       idx
);

   // Invalid words (none or several bits set) report index 0.
   always_comb begin
      vld = $onehot(in_q);
      idx = '0;
      if (vld) idx = PH_W'(onehot_to_idx(MAX_PHASES'(in_q), NUM_PHASES));
   end

endmodule

// File: rtl/sequential_pulse_monitor.sv
// rtl/sequential_pulse_monitor.sv - receive-side order checker for the one-hot pulse bus; SEQ_MON_ERR_CLR_EN adds err_clr
module sequential_pulse_monitor
   import seq_pulse_pkg::*;
#(
   parameter int NUM_PHASES = DEF_NUM_PHASES,
   parameter int LOCK_CNT   = 2,
   parameter int ERR_CNT_W  = 8
) (
   input logic                       clk,
   input logic                       rst_n,
   sequential_pulse_monitor_if.slave bus
);

   localparam int                   PH_W    = $clog2(NUM_PHASES);
   localparam int                   GOOD_W  = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
   localparam logic [PH_W-1:0]      LAST_PH = PH_W'(NUM_PHASES - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   logic [NUM_PHASES-1:0] in_q;
   logic                  dec_vld;
   logic [PH_W-1:0]       dec_idx;

   mon_state_e            state;
   logic [PH_W-1:0]       exp_phase;
   logic [PH_W-1:0]       exp_next;
   logic [GOOD_W-1:0]     good_cnt;

   logic                  match;
   logic                  is_p0;
   logic                  is_last;
   logic                  seq_good;
   logic                  err_hit;
   logic [ERR_CNT_W-1:0]  err_base;
   logic [ERR_CNT_W-1:0]  err_next;

   logic [PH_W-1:0]       phase_idx_q;
   logic                  phase_vld_q;
   logic                  locked_q;
   logic                  seq_done_q;
   logic                  seq_err_q;
   logic [ERR_CNT_W-1:0]  err_cnt_q;

   pulse_onehot_decode #(.NUM_PHASES(NUM_PHASES)) u_decode (
      .in_q (in_q),
      .vld  (dec_vld),
      .idx  (dec_idx)
   );

   always_comb begin
      match    = dec_vld && (dec_idx == exp_phase);
      is_p0    = dec_vld && (dec_idx == '0);
      is_last  = (dec_idx == LAST_PH);
      exp_next = (exp_phase == LAST_PH) ? '0 : exp_phase + PH_W'(1);
      seq_good = (int'(good_cnt) + 1 == LOCK_CNT);
      err_hit  = (state == LOCKED) && !match;
`ifdef SEQ_MON_ERR_CLR_EN
      // Clear first, then count, so a coincident error leaves exactly one.
      err_base = bus.err_clr ? '0 : err_cnt_q;
`else
      err_base = err_cnt_q;
`endif
      err_next = err_base;
      if (err_hit && err_base != ERR_MAX) err_next = err_base + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q        <= '0;
         state       <= HUNT;
         exp_phase   <= '0;
         good_cnt    <= '0;
         phase_idx_q <= '0;
         phase_vld_q <= 1'b0;
         locked_q    <= 1'b0;
         seq_done_q  <= 1'b0;
         seq_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         in_q        <= bus.pulse_in;
         phase_idx_q <= dec_idx;
         phase_vld_q <= dec_vld;
         seq_done_q  <= 1'b0;
         seq_err_q   <= err_hit;
         err_cnt_q   <= err_next;
         case (state)
            HUNT: begin
               locked_q <= 1'b0;
               if (is_p0) begin
                  state     <= TRACK;
                  exp_phase <= PH_W'(1);
                  good_cnt  <= '0;
               end
            end
            TRACK: begin
               locked_q <= 1'b0;
               if (match) begin
                  exp_phase <= exp_next;
                  if (is_last) begin
                     if (seq_good) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                        good_cnt <= '0;
                     end else begin
                        good_cnt <= good_cnt + GOOD_W'(1);
                     end
                  end
               end else if (is_p0) begin
                  exp_phase <= PH_W'(1);
                  good_cnt  <= '0;
               end else begin
                  state     <= HUNT;
                  exp_phase <= '0;
               end
            end
            LOCKED: begin
               if (match) begin
                  locked_q   <= 1'b1;
                  exp_phase  <= exp_next;
                  seq_done_q <= is_last;
               end else begin
                  // Any break costs the lock; relock needs LOCK_CNT fresh sequences.
                  locked_q <= 1'b0;
                  good_cnt <= '0;
                  if (is_p0) begin
                     state     <= TRACK;
                     exp_phase <= PH_W'(1);
                  end else begin
                     state     <= HUNT;
                     exp_phase <= '0;
                  end
               end
            end
            default: begin
               state     <= HUNT;
               locked_q  <= 1'b0;
               exp_phase <= '0;
               good_cnt  <= '0;
            end
         endcase
      end
   end

   assign bus.phase_idx = phase_idx_q;
   assign bus.phase_vld = phase_vld_q;
   assign bus.locked    = locked_q;
   assign bus.seq_done  = seq_done_q;
   assign bus.seq_err   = seq_err_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule
